// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file definitions and helpers for the write-port arbiter.
package regfile_write_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  function automatic logic [REG_COUNT-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
    return REG_COUNT'(1) << a;
  endfunction
endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Synchronous FIFO buffering long-latency results; exposes per-entry addr/valid
// so the parent can build the pending-destination mask.
module regfile_write_arbiter_wb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            push_addr,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [ADDR_W-1:0]            head_addr,
  output logic [DATA_W-1:0]            head_data,
  output logic [DEPTH-1:0]             ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]            mem_data [DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [PTR_W:0]               count;
  logic                         push_ok, pop_ok;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign ent_addr  = mem_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      // push and pop never hit the same slot: a pop needs !empty, a push needs !full
      if (pop_ok) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between pipeline writeback
// (priority) and buffered long-latency results, with starvation and WAW forcing.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       pend_mask
);
  // Handshake: an LU result transfers on a cycle where lu_valid && lu_ready;
  // lu_ready depends only on FIFO fullness, never on lu_valid or a same-cycle pop.
  localparam int WAIT_W = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT - 1);

  logic                             full, empty, push, pop;
  logic [ADDR_W-1:0]                head_addr;
  logic [DATA_W-1:0]                head_data;
  logic [FIFO_DEPTH-1:0]            ent_valid;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [WAIT_W-1:0]                wait_cnt;
  logic [31:0]                      pend_raw;
  logic                             wb_hit, force_b, grant_lu, grant_wb;

  regfile_write_arbiter_wb_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk), .rst(rst), .push(push), .push_addr(lu_addr), .push_data(lu_data),
    .pop(pop), .full(full), .empty(empty), .head_addr(head_addr),
    .head_data(head_data), .ent_valid(ent_valid), .ent_addr(ent_addr)
  );

  always_comb begin
    pend_raw = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i]) pend_raw = pend_raw | addr_onehot(ent_addr[i]);
    end
  end

  assign pend_mask = pend_raw & {32{rst}};
  assign lu_ready  = rst && !full;
  // x0 results are accepted but dropped: writes to x0 have no architectural effect
  assign push      = lu_valid && lu_ready && (lu_addr != REG_X0);

  assign wb_hit  = wb_valid && (wb_addr != REG_X0) && pend_raw[wb_addr];
  assign force_b = !empty && ((wait_cnt == WAIT_MAX) || wb_hit);

  always_comb begin
    grant_lu = 1'b0;
    grant_wb = 1'b0;
    if (force_b)        grant_lu = 1'b1;
    else if (wb_valid)  grant_wb = 1'b1;
    else if (!empty)    grant_lu = 1'b1;
  end

  assign pop      = rst && grant_lu;
  assign wb_stall = rst && force_b && wb_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else if (grant_lu) begin
      RegWrite  <= 1'b1;
      WriteAddr <= head_addr;
      WriteData <= head_data;
    end else if (grant_wb && (wb_addr != REG_X0)) begin
      RegWrite  <= 1'b1;
      WriteAddr <= wb_addr;
      WriteData <= wb_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || empty || pop)      wait_cnt <= '0;
    else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
  end
endmodule
